regbank_wb_arbiter: RTL
=======================

# regbank_wb_arbiter

Write-port controller for the MIPS register bank. Shares the bank's single write port (we3/a3/wd3) between two writeback requesters, the ALU result path and the memory load path, using a valid/ready handshake with round-robin priority. Also sequences a bulk clear of registers 1–31 on command. Sits between the writeback stage and the regbank; the read ports (a1/a2/rd1/rd2) are not touched.

## Interface
Parameters:
- none (widths fixed: 5-bit register address, 32-bit data, 32 registers)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU requester has a write pending
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU write data
- alu_ready  out  1  combinational; ALU write accepted this cycle when alu_valid & alu_ready
- mem_valid  in  1  load requester has a write pending
- mem_addr  in  5  load destination register
- mem_data  in  32  load write data
- mem_ready  out  1  combinational; load write accepted this cycle when mem_valid & mem_ready
- clr_req  in  1  single-cycle pulse requesting a clear of r1..r31
- clr_busy  out  1  registered; high while the clear sequence drives the write port
- we3  out  1  registered write enable to regbank
- a3  out  5  registered write address to regbank
- wd3  out  32  registered write data to regbank

## Operation
- States: IDLE, CLEAR. Registers: state, clear pointer ptr[4:0], last_grant (0 = ALU, 1 = MEM), we3/a3/wd3, clr_busy.
- Reset (async, any state): state=IDLE, ptr=0, last_grant=1, we3=0, a3=0, wd3=0, clr_busy=0. Reset during CLEAR aborts the sweep; no further clear writes are issued.
- IDLE, clr_req=1: clear wins over both requesters; alu_ready=mem_ready=0 this cycle; next state CLEAR, ptr=1.
- IDLE, clr_req=0, arbitration:
  - only alu_valid: alu_ready=1, mem_ready=0.
  - only mem_valid: mem_ready=1, alu_ready=0.
  - both valid: grant the requester not equal to last_grant; the other ready=0.
  - neither valid: both ready=0; we3 <= 0 next cycle.
  - the ready of a non-valid requester is 0.
- On an accepted write: a3 <= addr, wd3 <= data, last_grant <= granted id; we3 <= 1, except addr=0, where we3 <= 0 (the $zero write is suppressed but still acknowledged and still updates last_grant).
- When no write is issued: we3 <= 0; a3/wd3 keep their previous values.
- CLEAR: each cycle we3 <= 1, a3 <= ptr, wd3 <= 0, ptr <= ptr+1. After issuing ptr=31 the next state is IDLE. Both readys are 0 in every CLEAR cycle. clr_req is ignored in CLEAR. last_grant is unchanged by a clear.
- Requesters may hold valid with stable addr/data while ready=0; the block never drops or duplicates a held request.

## Timing
- Write latency 1: a handshake in cycle T gives we3/a3/wd3 valid in cycle T+1, registered. The regbank commits on the T+1 edge.
- Throughput: one write per cycle in IDLE.
- Clear: clr_req in IDLE at cycle T gives we3=1 with a3=1,2,…,31 in cycles T+1..T+31, and clr_busy=1 in exactly T+1..T+31.
  - State is CLEAR in cycles T+1..T+31 and IDLE again in T+32.
  - The earliest request acceptable after a clear is in cycle T+32; its write appears in T+33.
  - we3=0 in T+32 unless a write was accepted in T+31 (impossible, since readys are 0), so we3=0 in T+32.
- No combinational path from any input to we3/a3/wd3/clr_busy. Paths from inputs to alu_ready/mem_ready are combinational.

## Test plan
- Reset: assert rst mid-cycle with random inputs → we3=0, a3=0, wd3=0, clr_busy=0 immediately, without waiting for a clock edge.
- Single ALU write: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF in cycle T → alu_ready=1 in T; we3=1, a3=5, wd3=0xDEADBEEF in T+1; regbank read of r5 returns 0xDEADBEEF afterwards.
- Contention: both valid for 4 cycles from reset (ALU addr 3/data 0x11, MEM addr 4/data 0x22, held until accepted, then re-asserted) → grants alternate ALU, MEM, ALU, MEM; a3 sequence 3,4,3,4 on T+1..T+4.
- $zero suppression: mem_valid=1, mem_addr=0, mem_data=0xFFFFFFFF → mem_ready=1, we3 stays 0; next ALU+MEM tie goes to ALU; r0 still reads 0.
- Clear with contention: preload r1..r31 with nonzero data; pulse clr_req while alu_valid=1 (addr 7, data 0x77) is held → alu_ready=0 for 32 cycles; 31 writes with a3=1..31 and wd3=0; clr_busy high for exactly 31 cycles; then the ALU write is accepted and r7 = 0x77; all other registers read 0.
- Reset mid-clear: assert rst when a3=10 during CLEAR → we3=0 and clr_busy=0 at once; after reset, r11..r31 keep their preloaded values.

Source files
------------

// File: rtl/regbank_wb_arbiter.sv
// Round-robin share of the regbank write port between ALU and load writeback, plus r1..r31 clear sweep.
// Latency 1 (registered we3/a3/wd3); readys are combinational and held low during a clear or reset.
module regbank_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state, state_nxt;
    logic [4:0]  ptr, ptr_nxt;
    logic        last_grant, last_grant_nxt;
    logic        we3_nxt, clr_busy_nxt;
    logic [4:0]  a3_nxt;
    logic [31:0] wd3_nxt;
    logic        grant_alu, grant_mem;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!rst && state == IDLE && !clr_req) begin
            if (alu_valid && (!mem_valid || last_grant))
                grant_alu = 1'b1;
            else if (mem_valid)
                grant_mem = 1'b1;
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        last_grant_nxt = last_grant;
        we3_nxt        = 1'b0;
        a3_nxt         = a3;
        wd3_nxt        = wd3;
        clr_busy_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt    = CLEAR;
                    ptr_nxt      = 5'd1;
                    we3_nxt      = 1'b1;
                    a3_nxt       = 5'd1;
                    wd3_nxt      = '0;
                    clr_busy_nxt = 1'b1;
                end else if (grant_alu) begin
                    last_grant_nxt = 1'b0;
                    we3_nxt        = |alu_addr;
                    a3_nxt         = alu_addr;
                    wd3_nxt        = alu_data;
                end else if (grant_mem) begin
                    last_grant_nxt = 1'b1;
                    we3_nxt        = |mem_addr;
                    a3_nxt         = mem_addr;
                    wd3_nxt        = mem_data;
                end
            end
            CLEAR: begin
                // ptr holds the address currently on a3; r31 is the last one.
                if (ptr == 5'd31) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt      = ptr + 5'd1;
                    we3_nxt      = 1'b1;
                    a3_nxt       = ptr + 5'd1;
                    wd3_nxt      = '0;
                    clr_busy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            last_grant <= 1'b1;
            we3        <= 1'b0;
            a3         <= '0;
            wd3        <= '0;
            clr_busy   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            last_grant <= last_grant_nxt;
            we3        <= we3_nxt;
            a3         <= a3_nxt;
            wd3        <= wd3_nxt;
            clr_busy   <= clr_busy_nxt;
        end
    end

endmodule
